// File: rtl/chess_eval_pkg.sv
// Shared constants, state encoding and entry helpers for the positional evaluation blocks.
package chess_eval_pkg;

    localparam int ENTRY_W = 6;
    localparam int SQUARES = 64;
    localparam int SUM_W   = 12;
    localparam int IDX_W   = $clog2(SQUARES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rank flip: a1 <-> a8, so black reads the table from its own side of the board.
    function automatic logic [IDX_W-1:0] mirror_sq(input logic [IDX_W-1:0] sq);
        return sq ^ IDX_W'(56);
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_entry(input logic [ENTRY_W-1:0] e);
        return {{(SUM_W-ENTRY_W){e[ENTRY_W-1]}}, e};
    endfunction

endpackage

// File: rtl/pst_score_accumulator_lane_adder.sv
// Combinational sum of LANES masked, sign-extended table entries.
module pst_lane_adder
    import chess_eval_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES*ENTRY_W-1:0] entries,
    input  logic [LANES-1:0]         mask,
    output logic signed [SUM_W-1:0] lane_sum
);

    // Add every occupied lane's entry; unoccupied lanes contribute nothing.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) begin
                lane_sum = lane_sum + sext_entry(entries[l*ENTRY_W +: ENTRY_W]);
            end else begin
                lane_sum = lane_sum;
            end
        end
    end

endmodule

// File: rtl/pst_score_accumulator.sv
// Latches a piece-square table and occupancy, walks the board LANES squares per cycle,
// and reports the signed sum of entries on occupied squares.
module pst_score_accumulator
    import chess_eval_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [SQUARES*ENTRY_W-1:0] table_in,
    input  logic [SQUARES-1:0]         occ,
    input  logic                       mirror,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [SUM_W-1:0]           score
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SQUARES - LANES);

    generate
        if (SQUARES % LANES != 0) begin : g_lanes_check
            $error("pst_score_accumulator: SQUARES must be a multiple of LANES");
        end
    endgenerate

    state_t                     state_r;
    logic [IDX_W-1:0]           idx_r;
    logic signed [SUM_W-1:0]    acc_r;
    logic [SUM_W-1:0]           score_r;
    logic                       ready_r;
    logic                       busy_r;
    logic                       done_r;
    logic [SQUARES*ENTRY_W-1:0] table_r;
    logic [SQUARES-1:0]         occ_r;
    logic                       mirror_r;

    logic [LANES*ENTRY_W-1:0]   lane_entries_s;
    logic [LANES-1:0]           lane_mask_s;
    logic signed [SUM_W-1:0]    lane_sum_s;
    logic                       accept_s;

    assign accept_s = start & ready_r;

    // Gather the current group of squares; occupancy always uses the real square,
    // only the table lookup is mirrored.
    always_comb begin
        logic [IDX_W-1:0] sq_s;
        logic [IDX_W-1:0] src_s;
        lane_entries_s = '0;
        lane_mask_s    = '0;
        sq_s           = '0;
        src_s          = '0;
        for (int l = 0; l < LANES; l++) begin
            sq_s = idx_r + IDX_W'(l);
            if (mirror_r) begin
                src_s = mirror_sq(sq_s);
            end else begin
                src_s = sq_s;
            end
            lane_entries_s[l*ENTRY_W +: ENTRY_W] = table_r[src_s*ENTRY_W +: ENTRY_W];
            lane_mask_s[l]                       = occ_r[sq_s];
        end
    end

    pst_lane_adder #(
        .LANES    (LANES)
    ) u_lane_adder (
        .entries  (lane_entries_s),
        .mask     (lane_mask_s),
        .lane_sum (lane_sum_s)
    );

    // Control FSM, square counter, accumulator, input latches and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            acc_r    <= '0;
            score_r  <= '0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            table_r  <= '0;
            occ_r    <= '0;
            mirror_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (idx_r == LAST_IDX) begin
                        score_r <= acc_r + lane_sum_s;
                        acc_r   <= acc_r + lane_sum_s;
                        idx_r   <= '0;
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        acc_r   <= acc_r + lane_sum_s;
                        idx_r   <= idx_r + IDX_W'(LANES);
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    acc_r   <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
            // Accepting a request overrides the counter and accumulator for a fresh walk.
            if (accept_s) begin
                table_r  <= table_in;
                occ_r    <= occ;
                mirror_r <= mirror;
                acc_r    <= '0;
                idx_r    <= '0;
            end
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign score = score_r;

endmodule

// File: tb/tb_pst_score_accumulator.sv
// Directed and randomized checks of pst_score_accumulator against a board-level sum model.
module tb_pst_score_accumulator;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [383:0] table_in = '0;
    logic [63:0]  occ = '0;
    logic         mirror = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [11:0]  score;

    int n_checks = 0;
    int n_fail   = 0;

    pst_score_accumulator dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .table_in (table_in),
        .occ      (occ),
        .mirror   (mirror),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .score    (score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] score_ext();
        return {{20{score[11]}}, score};
    endfunction

    function automatic logic [383:0] fill_table(input logic [5:0] v);
        logic [383:0] t;
        for (int i = 0; i < 64; i++) t[6*i +: 6] = v;
        return t;
    endfunction

    function automatic logic [383:0] rand_table();
        logic [383:0] t;
        for (int i = 0; i < 64; i++) t[6*i +: 6] = 6'($urandom);
        return t;
    endfunction

    // Reference: walk ranks/files; black reads the entry on the opposite rank, same file.
    function automatic int model(input logic [383:0] t, input logic [63:0] o, input logic m);
        int s = 0;
        logic signed [5:0] e;
        for (int rank = 0; rank < 8; rank++) begin
            for (int file = 0; file < 8; file++) begin
                int sq  = rank * 8 + file;
                int src = m ? (7 - rank) * 8 + file : sq;
                if (o[sq]) begin
                    e = t[6*src +: 6];
                    s += e;
                end
            end
        end
        return s;
    endfunction

    task automatic accept(input logic [383:0] t, input logic [63:0] o, input logic m);
        @(negedge clk);
        table_in = t; occ = o; mirror = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        table_in = rand_table(); occ = {$urandom, $urandom}; mirror = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_job(input string tag, input logic [383:0] t, input logic [63:0] o,
                           input logic m, input int exp);
        int cyc;
        check({tag, "_ready"}, ready, 1);
        accept(t, o, m);
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        check({tag, "_lat"}, cyc, 16);
        check({tag, "_score"}, score_ext(), exp);
    endtask

    initial begin
        logic [383:0] t;
        logic [63:0]  o;
        logic         m;
        int           cyc;
        int           done_cnt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_score", score_ext(), 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_job("zero_tbl", '0, '1, 1'b0, 0);
        run_job("ones_16", fill_table(6'd1), 64'h0000_0000_0000_FFFF, 1'b0, 16);
        run_job("ones_64", fill_table(6'd1), '1, 1'b0, 64);
        run_job("min_edge", fill_table(6'h20), '1, 1'b0, -2048);
        run_job("max_edge", fill_table(6'd31), '1, 1'b0, 1984);

        t = '0;
        t[5:0] = 6'd5;
        run_job("mirror_off", t, 64'h0100_0000_0000_0000, 1'b0, 0);
        run_job("mirror_on", t, 64'h0100_0000_0000_0000, 1'b1, 5);

        // Start pulsed mid-run with different data must be ignored.
        accept(fill_table(6'd2), 64'h0000_0000_00FF_00FF, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        table_in = fill_table(6'd1); occ = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        cyc = 6;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("midstart_lat", cyc, 16);
        check("midstart_score", score_ext(), 32);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("midstart_single_done", done_cnt, 0);

        // Reset during RUN cycle 8 aborts immediately.
        accept(fill_table(6'd3), '1, 1'b0);
        repeat (7) begin @(posedge clk); #1; end
        check("abort_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
        check("abort_score", score_ext(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_job("after_abort", fill_table(6'h3F), 64'h8000_0000_0000_0001, 1'b1, -2);

        // Start held high through DONE gives back-to-back runs with a 17-cycle period.
        @(negedge clk);
        t = rand_table(); o = {$urandom, $urandom}; m = 1'b1;
        table_in = t; occ = o; mirror = m; start = 1'b1;
        @(posedge clk); #1;
        wait_done(cyc);
        check("b2b_first_lat", cyc, 16);
        check("b2b_first_score", score_ext(), model(t, o, m));
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 100);
        check("b2b_period", cyc, 17);
        check("b2b_second_score", score_ext(), model(t, o, m));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_done_pulse", done, 0);

        for (int n = 0; n < 12; n++) begin
            t = rand_table();
            case (n % 4)
                0:       o = '1;
                1:       o = {$urandom, $urandom} & {$urandom, $urandom};
                default: o = {$urandom, $urandom};
            endcase
            m = 1'($urandom);
            run_job($sformatf("rand%0d", n), t, o, m, model(t, o, m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
